chinx_load_unit: RTL
====================

// Module: chinx_load_unit
// PURPOSE
//  Load-data return stage of the chinx memory pipe; one outstanding load.
//  - Accepts a load from EX and issues a word-aligned bus read.
//  - Selects the byte/half lane from the returned word, then sign/zero-extends it
//    via the existing chinx_sext8 / chinx_sext16 extenders.
//  - Hands the 32-bit result to write-back; reports misaligned, bus-error and timeout faults.
// PARAMETERS
//  TIMEOUT  255  max cycles in WAIT without bus_rvalid_i before timeout fault (1..255)
// PORTS
//  clk_i         in   1   single clock, all state on rising edge
//  rst_i         in   1   synchronous, active-high reset
//  flush_i       in   1   pipeline flush; kills the in-flight load
//  ld_valid_i    in   1   load request valid
//  ld_ready_o    out  1   unit can accept a load (state==IDLE)
//  ld_addr_i     in   32  byte address
//  ld_size_i     in   2   00 byte, 01 half, 10 word, 11 reserved (treated as misaligned)
//  ld_signed_i   in   1   1 = sign-extend, 0 = zero-extend
//  ld_rd_i       in   5   destination register tag
//  bus_req_o     out  1   read request, held until bus_gnt_i
//  bus_addr_o    out  32  {ld_addr[31:2],2'b00}
//  bus_gnt_i     in   1   request accepted this cycle
//  bus_rvalid_i  in   1   read data valid (one cycle)
//  bus_rdata_i   in   32  read data
//  bus_err_i     in   1   bus error, qualified by bus_rvalid_i
//  wb_valid_o    out  1   result valid, held until wb_ready_i
//  wb_ready_i    in   1   write-back accepts
//  wb_rd_o       out  5   destination tag
//  wb_data_o     out  32  extended load data
//  exc_valid_o   out  1   one-cycle fault pulse
//  exc_code_o    out  2   01 misaligned, 10 bus error, 11 timeout
//  exc_addr_o    out  32  faulting byte address
// BEHAVIOUR
//  - Reset: state IDLE; bus_req_o, wb_valid_o, exc_valid_o = 0; wb_data_o, wb_rd_o,
//    exc_code_o, exc_addr_o, bus_addr_o = 0; timeout counter = 0.
//  - FSM: IDLE, REQ, WAIT, RESP, DRAIN.
//  - IDLE
//    - ld_valid_i & ld_ready_o latches addr/size/signed/rd.
//    - Misaligned if (half & a[0]) | (word & a[1:0]!=0) | size==11.
//    - Misaligned: no bus access; exc_valid_o pulses next cycle (code 01); stay IDLE.
//    - Otherwise go to REQ.
//  - REQ: bus_req_o=1 (registered, first asserted the cycle after accept).
//    - bus_gnt_i -> WAIT, counter cleared.
//  - WAIT: counter increments each cycle.
//    - bus_rvalid_i & !bus_err_i -> RESP: wb_valid_o=1 next cycle with aligned, extended data.
//    - bus_rvalid_i & bus_err_i -> exc pulse code 10 -> IDLE.
//    - Counter reaching TIMEOUT without rvalid -> exc pulse code 11 -> IDLE.
//    - Later stray rvalid is ignored in IDLE.
//  - RESP: hold wb_* stable until wb_ready_i, then IDLE.
//    - ld_ready_o stays 0 in RESP; no new load is accepted in the handshake cycle.
//  - Lane select
//    - byte: rdata[8*a[1:0]+:8].
//    - half: rdata[16*a[1]+:16].
//    - word: passthrough.
//    - ld_signed_i=1 uses the sext output; 0 zero-fills.
//  - Latency, no bus wait: accept t0, req t1, gnt t1, rvalid t2, wb_valid_o t3.
//  - Flush
//    - IDLE: no effect; a same-cycle ld_valid_i is not accepted.
//    - REQ: drop bus_req_o next cycle -> IDLE.
//    - WAIT: -> DRAIN.
//    - RESP: drop wb_valid_o -> IDLE.
//    - Pending misaligned pulse: suppressed.
//    - Flush never produces an exception.
//  - DRAIN: wait for bus_rvalid_i (data and error discarded) or timeout (silent) -> IDLE.
//    ld_ready_o=0.
//  - rst_i overrides all; a mid-transaction reset abandons the bus read and asserts nothing.
//  - exc_valid_o and wb_valid_o are never high in the same cycle.
// STRUCTURE
//  - chinx_lsu_pkg
//    - ld_size_e (LD_B, LD_H, LD_W)
//    - exc_code_e (EXC_MISALIGN, EXC_BUSERR, EXC_TIMEOUT)
//    - ld_state_e (IDLE, REQ, WAIT, RESP, DRAIN)
//  - Sub-module chinx_load_align: combinational lane select plus chinx_sext8/chinx_sext16
//    instances. FSM, counter and handshakes stay in chinx_load_unit.
// TESTING
//  - lb signed, addr 0x103, rdata 0x80_22_33_44 -> wb_data_o 0xFFFF_FF80, bus_addr_o 0x100, wb at t3.
//  - lhu, addr 0x202, rdata 0x9ABC_1234 -> wb_data_o 0x0000_9ABC.
//    Same with lh -> 0xFFFF_9ABC.
//  - lw, addr 0x301 -> no bus_req_o; exc_valid_o 1 cycle, code 01, exc_addr_o 0x301; ld_ready_o back to 1.
//  - lw, gnt but no rvalid, TIMEOUT=4 -> code 11 after 4 WAIT cycles.
//    rvalid+err instead -> code 10.
//  - flush in WAIT, rvalid 3 cycles later -> no wb_valid_o or exc; ld_ready_o 1 the cycle after rvalid.
//  - wb_ready_i low 5 cycles -> wb_valid_o/wb_data_o held; rst_i mid-WAIT -> all outputs 0 next cycle.

Source files
------------

// File: rtl/chinx_lsu_pkg.sv
// Shared types and helpers for the chinx load/store pipe.
package chinx_lsu_pkg;

    typedef enum logic [1:0] {
        LD_B = 2'b00,
        LD_H = 2'b01,
        LD_W = 2'b10
    } ld_size_e;

    typedef enum logic [1:0] {
        EXC_MISALIGN = 2'b01,
        EXC_BUSERR   = 2'b10,
        EXC_TIMEOUT  = 2'b11
    } exc_code_e;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        RESP,
        DRAIN
    } ld_state_e;

    localparam int CNT_W = 8;

    // Size 2'b11 is reserved and reported as misaligned.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
        return ((size == LD_H) && a[0]) || ((size == LD_W) && (a != 2'b00)) || (size == 2'b11);
    endfunction

endpackage

// File: rtl/chinx_load_align.sv
// Lane select and sign/zero extension of a returned bus word.
module chinx_load_align
    import chinx_lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] data
);
    logic [7:0]  lanes [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] byte_sx;
    logic [31:0] half_sx;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lanes[gi] = rdata[8*gi +: 8];
        end
    endgenerate

    assign byte_sel = lanes[addr_lo];
    assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    chinx_sext8 u_sext8 (
        .din  (byte_sel),
        .dout (byte_sx)
    );

    chinx_sext16 u_sext16 (
        .din  (half_sel),
        .dout (half_sx)
    );

    always_comb begin
        data = rdata;
        case (size)
            LD_B:    data = sign_ext ? byte_sx : {24'b0, byte_sel};
            LD_H:    data = sign_ext ? half_sx : {16'b0, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/chinx_sext16.sv
// Sign-extends a halfword to 32 bits.
module chinx_sext16 (
    input  logic [15:0] din,
    output logic [31:0] dout
);
    assign dout = {{16{din[15]}}, din};
endmodule

// File: rtl/chinx_sext8.sv
// Sign-extends a byte to 32 bits.
module chinx_sext8 (
    input  logic [7:0]  din,
    output logic [31:0] dout
);
    assign dout = {{24{din[7]}}, din};
endmodule

// File: rtl/chinx_load_unit.sv
// Load-data return stage: one outstanding word-aligned bus read, lane
// extraction, write-back handshake and fault reporting.
module chinx_load_unit
    import chinx_lsu_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        ld_valid_i,
    output logic        ld_ready_o,
    input  logic [31:0] ld_addr_i,
    input  logic [1:0]  ld_size_i,
    input  logic        ld_signed_i,
    input  logic [4:0]  ld_rd_i,
    output logic        bus_req_o,
    output logic [31:0] bus_addr_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_err_i,
    output logic        wb_valid_o,
    input  logic        wb_ready_i,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o,
    output logic        exc_valid_o,
    output logic [1:0]  exc_code_o,
    output logic [31:0] exc_addr_o
);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    ld_state_e        state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [31:0]      addr_reg, addr_next;
    logic [1:0]       size_reg, size_next;
    logic             signed_reg, signed_next;
    logic [4:0]       rd_reg, rd_next;
    logic             bus_req_reg, bus_req_next;
    logic [31:0]      bus_addr_reg, bus_addr_next;
    logic             wb_valid_reg, wb_valid_next;
    logic [31:0]      wb_data_reg, wb_data_next;
    logic [4:0]       wb_rd_reg, wb_rd_next;
    logic             exc_valid_reg, exc_valid_next;
    logic [1:0]       exc_code_reg, exc_code_next;
    logic [31:0]      exc_addr_reg, exc_addr_next;
    logic [31:0]      align_data;

    chinx_load_align u_align (
        .rdata    (bus_rdata_i),
        .addr_lo  (addr_reg[1:0]),
        .size     (size_reg),
        .sign_ext (signed_reg),
        .data     (align_data)
    );

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        addr_next      = addr_reg;
        size_next      = size_reg;
        signed_next    = signed_reg;
        rd_next        = rd_reg;
        bus_req_next   = bus_req_reg;
        bus_addr_next  = bus_addr_reg;
        wb_valid_next  = wb_valid_reg;
        wb_data_next   = wb_data_reg;
        wb_rd_next     = wb_rd_reg;
        exc_valid_next = 1'b0;
        exc_code_next  = exc_code_reg;
        exc_addr_next  = exc_addr_reg;

        unique case (state_reg)
            IDLE: begin
                if (ld_valid_i && !flush_i) begin
                    addr_next   = ld_addr_i;
                    size_next   = ld_size_i;
                    signed_next = ld_signed_i;
                    rd_next     = ld_rd_i;
                    if (is_misaligned(ld_size_i, ld_addr_i[1:0])) begin
                        exc_valid_next = 1'b1;
                        exc_code_next  = EXC_MISALIGN;
                        exc_addr_next  = ld_addr_i;
                    end else begin
                        state_next    = REQ;
                        bus_req_next  = 1'b1;
                        bus_addr_next = {ld_addr_i[31:2], 2'b00};
                    end
                end
            end
            REQ: begin
                // A granted request still returns data, so a flush here must drain it.
                if (bus_gnt_i) begin
                    bus_req_next = 1'b0;
                    cnt_next     = '0;
                    state_next   = flush_i ? DRAIN : WAIT;
                end else if (flush_i) begin
                    bus_req_next = 1'b0;
                    state_next   = IDLE;
                end
            end
            WAIT: begin
                if (bus_rvalid_i) begin
                    state_next = IDLE;
                    if (!flush_i) begin
                        if (bus_err_i) begin
                            exc_valid_next = 1'b1;
                            exc_code_next  = EXC_BUSERR;
                            exc_addr_next  = addr_reg;
                        end else begin
                            state_next    = RESP;
                            wb_valid_next = 1'b1;
                            wb_data_next  = align_data;
                            wb_rd_next    = rd_reg;
                        end
                    end
                end else if (cnt_reg == TMO_LAST) begin
                    state_next = IDLE;
                    if (!flush_i) begin
                        exc_valid_next = 1'b1;
                        exc_code_next  = EXC_TIMEOUT;
                        exc_addr_next  = addr_reg;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                    if (flush_i) begin
                        state_next = DRAIN;
                    end
                end
            end
            RESP: begin
                if (flush_i || wb_ready_i) begin
                    wb_valid_next = 1'b0;
                    state_next    = IDLE;
                end
            end
            DRAIN: begin
                if (bus_rvalid_i || (cnt_reg == TMO_LAST)) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            addr_reg      <= '0;
            size_reg      <= '0;
            signed_reg    <= 1'b0;
            rd_reg        <= '0;
            bus_req_reg   <= 1'b0;
            bus_addr_reg  <= '0;
            wb_valid_reg  <= 1'b0;
            wb_data_reg   <= '0;
            wb_rd_reg     <= '0;
            exc_valid_reg <= 1'b0;
            exc_code_reg  <= '0;
            exc_addr_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            addr_reg      <= addr_next;
            size_reg      <= size_next;
            signed_reg    <= signed_next;
            rd_reg        <= rd_next;
            bus_req_reg   <= bus_req_next;
            bus_addr_reg  <= bus_addr_next;
            wb_valid_reg  <= wb_valid_next;
            wb_data_reg   <= wb_data_next;
            wb_rd_reg     <= wb_rd_next;
            exc_valid_reg <= exc_valid_next;
            exc_code_reg  <= exc_code_next;
            exc_addr_reg  <= exc_addr_next;
        end
    end

    assign ld_ready_o  = (state_reg == IDLE);
    assign bus_req_o   = bus_req_reg;
    assign bus_addr_o  = bus_addr_reg;
    assign wb_valid_o  = wb_valid_reg;
    assign wb_data_o   = wb_data_reg;
    assign wb_rd_o     = wb_rd_reg;
    assign exc_valid_o = exc_valid_reg;
    assign exc_code_o  = exc_code_reg;
    assign exc_addr_o  = exc_addr_reg;

endmodule
